packet_tx: RTL and testbench

//  Packet source for one router input port; drives i_Sig_Packet_Valid / i_Input_Data of the router receive FSM.

---
 rtl/packet_tx_if.sv | 52 +++++
 rtl/packet_tx.sv | 186 ++++++++++++++++++
 tb/tb_packet_tx.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/packet_tx_if.sv
// ---------------------------------------------------------------------------
// packet_tx_if
// Handshake bundle between a packet transmitter and its surroundings:
// the request/payload stream from the local host and the byte link to the
// router receive FSM.
//
//   i_Start            request a packet
//   i_Dest_Addr        destination FIFO (00/01/10 legal, 11 illegal)
//   i_Payload_Len      payload byte count
//   i_Payload_Data     payload stream byte
//   i_Payload_Valid    payload byte valid
//   o_Payload_Ready    transmitter accepts a payload byte
//   i_Sig_Busy         router busy; the byte on o_Data is held while high
//   o_Sig_Packet_Valid high during header and payload bytes
//   o_Data             header / payload / parity byte to the router
//   o_Done             one-cycle pulse after the parity byte is accepted
//   o_Error            one-cycle pulse after a rejected request
//   o_Sig_Tx_Busy      transmitter not idle
//
// modport master : the transmitter's view (drives the o_* signals)
// modport slave  : host / router / bench view (drives the i_* signals)
// ---------------------------------------------------------------------------
interface packet_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  i_Start;
    logic [1:0]            i_Dest_Addr;
    logic [5:0]            i_Payload_Len;
    logic [DATA_WIDTH-1:0] i_Payload_Data;
    logic                  i_Payload_Valid;
    logic                  o_Payload_Ready;
    logic                  i_Sig_Busy;
    logic                  o_Sig_Packet_Valid;
    logic [DATA_WIDTH-1:0] o_Data;
    logic                  o_Done;
    logic                  o_Error;
    logic                  o_Sig_Tx_Busy;

    modport master (
        input  i_Start, i_Dest_Addr, i_Payload_Len, i_Payload_Data,
               i_Payload_Valid, i_Sig_Busy,
        output o_Payload_Ready, o_Sig_Packet_Valid, o_Data, o_Done,
               o_Error, o_Sig_Tx_Busy
    );

    modport slave (
        output i_Start, i_Dest_Addr, i_Payload_Len, i_Payload_Data,
               i_Payload_Valid, i_Sig_Busy,
        input  o_Payload_Ready, o_Sig_Packet_Valid, o_Data, o_Done,
               o_Error, o_Sig_Tx_Busy
    );
endinterface

// File: rtl/packet_tx.sv
// ---------------------------------------------------------------------------
// packet_tx
// Store-and-forward packet source for one router input port. A whole payload
// is buffered from the local stream first, then header, payload and parity are
// sent back to back so the payload never has a gap (the router treats a low
// packet_valid as end of payload).
//
// Ports
//   clk    : clock, all logic on posedge
//   reset  : asynchronous, active-high reset
//   bus    : packet_tx_if.master (request, payload stream, router link)
//
// Header byte = {len, addr}. Parity byte = XOR of header and every payload byte.
// A byte on o_Data is consumed on a posedge with i_Sig_Busy low; while busy is
// high o_Data and o_Sig_Packet_Valid hold.
// ---------------------------------------------------------------------------
module packet_tx #(
    parameter int DATA_WIDTH  = 8,
    parameter int MAX_PAYLOAD = 63
) (
    input  logic          clk,
    input  logic          reset,
    packet_tx_if.master   bus
);
    localparam int LEN_W = 6;
    localparam int DEPTH = 1 << LEN_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HEADER,
        S_PAYLOAD,
        S_PARITY,
        S_GAP
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [1:0]            r_addr;
    logic [LEN_W-1:0]      r_len;
    logic [LEN_W-1:0]      r_wr_ptr;
    logic [LEN_W-1:0]      r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_parity;
    logic                  r_error;

    // payload buffer, inferred block RAM with registered read
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    logic                  w_start_illegal;
    logic                  w_ready;
    logic                  w_load_fire;
    logic                  w_last_load;
    logic                  w_consume;
    logic                  w_last_payload;
    logic [LEN_W-1:0]      w_rd_addr;
    logic [DATA_WIDTH-1:0] w_header;
    logic [DATA_WIDTH-1:0] w_req_header;

    assign w_start_illegal = (bus.i_Dest_Addr == 2'b11) ||
                             (int'(bus.i_Payload_Len) > MAX_PAYLOAD);
    assign w_header        = DATA_WIDTH'({r_len, r_addr});
    assign w_req_header    = DATA_WIDTH'({bus.i_Payload_Len, bus.i_Dest_Addr});

    // Ready is withheld entirely for a zero-length packet.
    assign w_ready        = (r_state == S_LOAD) && (r_wr_ptr != r_len);
    assign w_load_fire    = w_ready && bus.i_Payload_Valid;
    assign w_last_load    = (r_wr_ptr + LEN_W'(1)) == r_len;
    assign w_consume      = !bus.i_Sig_Busy;
    assign w_last_payload = (r_rd_ptr + LEN_W'(1)) == r_len;

    // Read one entry ahead when the current payload byte is consumed so the
    // registered read data is already the next byte in the following cycle.
    // In HEADER rd_ptr is 0, which prefetches the first payload byte.
    assign w_rd_addr = ((r_state == S_PAYLOAD) && w_consume) ?
                       (r_rd_ptr + LEN_W'(1)) : r_rd_ptr;

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- next state / outputs ----------------
    always_comb begin
        w_state_next           = r_state;
        bus.o_Payload_Ready    = 1'b0;
        bus.o_Sig_Packet_Valid = 1'b0;
        bus.o_Data             = '0;
        bus.o_Done             = 1'b0;
        bus.o_Error            = r_error;
        bus.o_Sig_Tx_Busy      = (r_state != S_IDLE);

        case (r_state)
            S_IDLE: begin
                if (bus.i_Start && !w_start_illegal) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                bus.o_Payload_Ready = w_ready;
                if (r_len == '0) begin
                    w_state_next = S_HEADER;
                end else if (w_load_fire && w_last_load) begin
                    w_state_next = S_HEADER;
                end
            end
            S_HEADER: begin
                bus.o_Sig_Packet_Valid = 1'b1;
                bus.o_Data             = w_header;
                if (w_consume) begin
                    w_state_next = (r_len == '0) ? S_PARITY : S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                bus.o_Sig_Packet_Valid = 1'b1;
                bus.o_Data             = r_rd_data;
                if (w_consume && w_last_payload) begin
                    w_state_next = S_PARITY;
                end
            end
            S_PARITY: begin
                bus.o_Data = r_parity;
                if (w_consume) begin
                    w_state_next = S_GAP;
                end
            end
            S_GAP: begin
                // Done pulse lands here: the cycle after parity was taken.
                bus.o_Done   = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr   <= '0;
            r_len    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_parity <= '0;
            r_error  <= 1'b0;
        end else begin
            r_error <= 1'b0;

            if ((r_state == S_IDLE) && bus.i_Start) begin
                r_addr <= bus.i_Dest_Addr;
                r_len  <= bus.i_Payload_Len;
                if (w_start_illegal) begin
                    r_error <= 1'b1;
                end else begin
                    r_parity <= w_req_header;
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                end
            end

            if (w_load_fire) begin
                r_wr_ptr <= r_wr_ptr + LEN_W'(1);
                r_parity <= r_parity ^ bus.i_Payload_Data;
            end

            if ((r_state == S_PAYLOAD) && w_consume) begin
                r_rd_ptr <= r_rd_ptr + LEN_W'(1);
            end
        end
    end

    // Buffer contents need no reset; the FSM never reads an unwritten entry.
    always_ff @(posedge clk) begin
        if (w_load_fire) begin
            r_mem[r_wr_ptr] <= bus.i_Payload_Data;
        end
        r_rd_data <= r_mem[w_rd_addr];
    end

endmodule

// File: tb/tb_packet_tx.sv
// ---------------------------------------------------------------------------
// tb_packet_tx
// Directed bench for packet_tx. Inputs are driven on the falling edge; a
// monitor records what the router side consumes on each rising edge.
// ---------------------------------------------------------------------------
module tb_packet_tx;
    logic clk   = 1'b0;
    logic reset = 1'b0;

    packet_tx_if #(.DATA_WIDTH(8)) bus ();

    packet_tx #(
        .DATA_WIDTH (8),
        .MAX_PAYLOAD(63)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] pay [0:7];

    // ---------------- monitor ----------------
    int          cyc           = 0;
    int          got_n         = 0;
    logic [63:0] got_bytes     = '0;
    logic [7:0]  last_par      = '0;
    int          done_n        = 0;
    int          err_n         = 0;
    int          valid_n       = 0;
    int          ready_n       = 0;
    int          hdr_cyc       = 0;
    int          done_cyc      = 0;
    int          prev_done_cyc = 0;
    logic        prev_valid    = 1'b0;
    logic [7:0]  prev_data     = '0;

    always @(posedge clk) begin
        cyc++;
        if (!reset) begin
            if (bus.o_Sig_Packet_Valid && !bus.i_Sig_Busy) begin
                got_bytes = {got_bytes[55:0], bus.o_Data};
                got_n++;
            end
            if (bus.o_Sig_Packet_Valid) valid_n++;
            if (bus.o_Sig_Packet_Valid && !prev_valid) hdr_cyc = cyc;
            if (bus.o_Done) begin
                // parity is the byte that sat on o_Data in the previous cycle
                done_n++;
                last_par      = prev_data;
                prev_done_cyc = done_cyc;
                done_cyc      = cyc;
            end
            if (bus.o_Error) err_n++;
            if (bus.o_Payload_Ready) ready_n++;
        end
        prev_valid = bus.o_Sig_Packet_Valid;
        prev_data  = bus.o_Data;
    end

    // ---------------- drive helpers ----------------
    task automatic start_pkt(input logic [1:0] a, input logic [5:0] l);
        @(negedge clk);
        bus.i_Start       = 1'b1;
        bus.i_Dest_Addr   = a;
        bus.i_Payload_Len = l;
        @(negedge clk);
        bus.i_Start = 1'b0;
    endtask

    task automatic feed(input int len, output logic ok);
        int i = 0;
        int guard = 0;
        ok = 1'b1;
        while (i < len) begin
            bus.i_Payload_Data  = pay[i];
            bus.i_Payload_Valid = 1'b1;
            if (bus.o_Payload_Ready) i++;
            @(negedge clk);
            guard++;
            if (guard > 200) begin
                ok = 1'b0;
                break;
            end
        end
        bus.i_Payload_Valid = 1'b0;
    endtask

    task automatic wait_done(input int d0, output logic ok);
        int g = 0;
        ok = 1'b1;
        while (done_n < d0 + 1) begin
            @(negedge clk);
            g++;
            if (g > 300) begin
                ok = 1'b0;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [12:0] outs;
        #1 reset = 1'b1;
        #2;
        outs = {bus.o_Sig_Packet_Valid, bus.o_Payload_Ready, bus.o_Done,
                bus.o_Error, bus.o_Sig_Tx_Busy, bus.o_Data};
        n_assert++;
        if (outs !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected %h", outs, 13'd0);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_assert++;
        if (bus.o_Sig_Tx_Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: tx_busy got %b expected 0", bus.o_Sig_Tx_Busy);
        end
        $display("reset released, outputs=%h", outs);
    endtask

    task automatic test_basic();
        int n0, d0, r0;
        logic ok1, ok2;
        n0 = got_n; d0 = done_n; r0 = ready_n;
        pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3;
        start_pkt(2'b01, 6'd3);
        feed(3, ok1);
        wait_done(d0, ok2);
        repeat (2) @(negedge clk);
        n_assert++;
        if (!(ok1 && ok2)) begin
            n_fail++;
            $display("FAIL basic_timeout: feed_ok %b done_ok %b expected 1 1", ok1, ok2);
        end
        n_assert++;
        if (got_n - n0 !== 4) begin
            n_fail++;
            $display("FAIL basic_count: got %0d bytes expected 4", got_n - n0);
        end
        n_assert++;
        if (got_bytes[31:0] !== 32'h0DA1B2C3) begin
            n_fail++;
            $display("FAIL basic_bytes: got %h expected 0da1b2c3", got_bytes[31:0]);
        end
        n_assert++;
        if (last_par !== 8'hDD) begin
            n_fail++;
            $display("FAIL basic_parity: got %h expected dd", last_par);
        end
        n_assert++;
        if (done_n - d0 !== 1) begin
            n_fail++;
            $display("FAIL basic_done: got %0d pulses expected 1", done_n - d0);
        end
        n_assert++;
        if (ready_n - r0 !== 3) begin
            n_fail++;
            $display("FAIL basic_ready: got %0d ready cycles expected 3", ready_n - r0);
        end
        n_assert++;
        if (done_cyc - hdr_cyc !== 5) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d cycles expected 5", done_cyc - hdr_cyc);
        end
        $display("packet addr=01 len=3 bytes=%h parity=%h", got_bytes[31:0], last_par);
    endtask

    task automatic test_busy();
        int n0, d0;
        logic ok1, ok2, bz_ok;
        n0 = got_n; d0 = done_n;
        bz_ok = 1'b1;
        pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3;
        fork
            begin
                start_pkt(2'b01, 6'd3);
                feed(3, ok1);
                wait_done(d0, ok2);
            end
            begin
                int g = 0;
                while (!(bus.o_Sig_Packet_Valid && bus.o_Data == 8'h0D) && g < 100) begin
                    @(negedge clk);
                    g++;
                end
                if (g >= 100) bz_ok = 1'b0;
                bus.i_Sig_Busy = 1'b1;
                repeat (2) @(negedge clk);
                bus.i_Sig_Busy = 1'b0;
                g = 0;
                while (!(bus.o_Sig_Packet_Valid && bus.o_Data == 8'hB2) && g < 100) begin
                    @(negedge clk);
                    g++;
                end
                if (g >= 100) bz_ok = 1'b0;
                bus.i_Sig_Busy = 1'b1;
                repeat (3) @(negedge clk);
                bus.i_Sig_Busy = 1'b0;
            end
        join
        repeat (2) @(negedge clk);
        n_assert++;
        if (!(ok1 && ok2 && bz_ok)) begin
            n_fail++;
            $display("FAIL busy_timeout: feed %b done %b busy %b expected 1 1 1", ok1, ok2, bz_ok);
        end
        n_assert++;
        if (got_n - n0 !== 4) begin
            n_fail++;
            $display("FAIL busy_count: got %0d bytes expected 4", got_n - n0);
        end
        n_assert++;
        if (got_bytes[31:0] !== 32'h0DA1B2C3) begin
            n_fail++;
            $display("FAIL busy_bytes: got %h expected 0da1b2c3", got_bytes[31:0]);
        end
        n_assert++;
        if (last_par !== 8'hDD) begin
            n_fail++;
            $display("FAIL busy_parity: got %h expected dd", last_par);
        end
        n_assert++;
        if (done_cyc - hdr_cyc !== 10) begin
            n_fail++;
            $display("FAIL busy_latency: got %0d cycles expected 10", done_cyc - hdr_cyc);
        end
        $display("packet addr=01 len=3 with busy bytes=%h parity=%h", got_bytes[31:0], last_par);
    endtask

    task automatic test_zero_len();
        int n0, d0, r0;
        logic ok;
        n0 = got_n; d0 = done_n; r0 = ready_n;
        start_pkt(2'b10, 6'd0);
        wait_done(d0, ok);
        repeat (2) @(negedge clk);
        n_assert++;
        if (!ok) begin
            n_fail++;
            $display("FAIL zero_timeout: done_ok %b expected 1", ok);
        end
        n_assert++;
        if (got_n - n0 !== 1 || got_bytes[7:0] !== 8'h02) begin
            n_fail++;
            $display("FAIL zero_header: got %0d bytes last %h expected 1 byte 02", got_n - n0, got_bytes[7:0]);
        end
        n_assert++;
        if (last_par !== 8'h02) begin
            n_fail++;
            $display("FAIL zero_parity: got %h expected 02", last_par);
        end
        n_assert++;
        if (ready_n - r0 !== 0) begin
            n_fail++;
            $display("FAIL zero_ready: got %0d ready cycles expected 0", ready_n - r0);
        end
        n_assert++;
        if (done_n - d0 !== 1) begin
            n_fail++;
            $display("FAIL zero_done: got %0d pulses expected 1", done_n - d0);
        end
        $display("packet addr=10 len=0 header=%h parity=%h", got_bytes[7:0], last_par);
    endtask

    task automatic test_error();
        int e0, v0, d0;
        e0 = err_n; v0 = valid_n; d0 = done_n;
        start_pkt(2'b11, 6'd2);
        repeat (5) @(negedge clk);
        n_assert++;
        if (err_n - e0 !== 1) begin
            n_fail++;
            $display("FAIL error_pulse: got %0d error cycles expected 1", err_n - e0);
        end
        n_assert++;
        if (valid_n - v0 !== 0) begin
            n_fail++;
            $display("FAIL error_valid: got %0d valid cycles expected 0", valid_n - v0);
        end
        n_assert++;
        if (bus.o_Sig_Tx_Busy !== 1'b0 || done_n - d0 !== 0) begin
            n_fail++;
            $display("FAIL error_idle: tx_busy %b done %0d expected 0 0", bus.o_Sig_Tx_Busy, done_n - d0);
        end
        $display("request addr=11 len=2 rejected, error cycles=%0d", err_n - e0);
    endtask

    task automatic test_reset_mid();
        int n0, d0, g;
        logic ok1, ok2, ok3;
        logic was_valid;
        logic [12:0] outs;
        n0 = got_n;
        for (int i = 0; i < 5; i++) pay[i] = 8'(8'h11 * (i + 1));
        start_pkt(2'b00, 6'd5);
        feed(5, ok1);
        g = 0;
        while (!(bus.o_Sig_Packet_Valid && (got_n - n0) >= 2) && g < 100) begin
            @(negedge clk);
            g++;
        end
        was_valid = bus.o_Sig_Packet_Valid;
        #2 reset = 1'b1;
        #1;
        outs = {bus.o_Sig_Packet_Valid, bus.o_Payload_Ready, bus.o_Done,
                bus.o_Error, bus.o_Sig_Tx_Busy, bus.o_Data};
        n_assert++;
        if (!(ok1 && was_valid)) begin
            n_fail++;
            $display("FAIL abort_setup: feed %b in_payload %b expected 1 1", ok1, was_valid);
        end
        n_assert++;
        if (outs !== 13'd0) begin
            n_fail++;
            $display("FAIL abort_outputs: got %h expected %h", outs, 13'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        $display("packet addr=00 len=5 aborted by reset, outputs=%h", outs);

        n0 = got_n; d0 = done_n;
        pay[0] = 8'h55;
        start_pkt(2'b00, 6'd1);
        feed(1, ok2);
        wait_done(d0, ok3);
        repeat (2) @(negedge clk);
        n_assert++;
        if (!(ok2 && ok3)) begin
            n_fail++;
            $display("FAIL after_reset_timeout: feed %b done %b expected 1 1", ok2, ok3);
        end
        n_assert++;
        if (got_n - n0 !== 2 || got_bytes[15:0] !== 16'h0455) begin
            n_fail++;
            $display("FAIL after_reset_bytes: got %0d bytes %h expected 2 bytes 0455", got_n - n0, got_bytes[15:0]);
        end
        n_assert++;
        if (last_par !== 8'h51) begin
            n_fail++;
            $display("FAIL after_reset_parity: got %h expected 51", last_par);
        end
        $display("packet addr=00 len=1 bytes=%h parity=%h", got_bytes[15:0], last_par);
    endtask

    task automatic test_back_to_back();
        int n0, d0, seen, g;
        n0 = got_n; d0 = done_n;
        seen = 0; g = 0;
        @(negedge clk);
        bus.i_Payload_Data  = 8'h3C;
        bus.i_Payload_Valid = 1'b1;
        bus.i_Dest_Addr     = 2'b01;
        bus.i_Payload_Len   = 6'd1;
        bus.i_Start         = 1'b1;
        while (seen < 2 && g < 200) begin
            @(negedge clk);
            g++;
            if (bus.o_Done) seen++;
        end
        bus.i_Start         = 1'b0;
        bus.i_Payload_Valid = 1'b0;
        repeat (4) @(negedge clk);
        n_assert++;
        if (done_n - d0 !== 2) begin
            n_fail++;
            $display("FAIL b2b_done: got %0d pulses expected 2", done_n - d0);
        end
        n_assert++;
        if (got_n - n0 !== 4 || got_bytes[31:0] !== 32'h053C053C) begin
            n_fail++;
            $display("FAIL b2b_bytes: got %0d bytes %h expected 4 bytes 053c053c", got_n - n0, got_bytes[31:0]);
        end
        n_assert++;
        if (last_par !== 8'h39) begin
            n_fail++;
            $display("FAIL b2b_parity: got %h expected 39", last_par);
        end
        n_assert++;
        if (hdr_cyc - prev_done_cyc < 1) begin
            n_fail++;
            $display("FAIL b2b_gap: got %0d cycles from done to header expected >=1", hdr_cyc - prev_done_cyc);
        end
        n_assert++;
        if (bus.o_Sig_Tx_Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: tx_busy %b expected 0", bus.o_Sig_Tx_Busy);
        end
        $display("two packets addr=01 len=1 bytes=%h gap=%0d", got_bytes[31:0], hdr_cyc - prev_done_cyc);
    endtask

    initial begin
        bus.i_Start         = 1'b0;
        bus.i_Dest_Addr     = 2'b00;
        bus.i_Payload_Len   = 6'd0;
        bus.i_Payload_Data  = 8'h00;
        bus.i_Payload_Valid = 1'b0;
        bus.i_Sig_Busy      = 1'b0;

        test_reset();
        test_basic();
        test_busy();
        test_zero_len();
        test_error();
        test_reset_mid();
        test_back_to_back();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
